rrf_flag_mt: RTL and testbench

//  Multi-thread, multi-write-port retirement register for the architectural flags.

---
 rtl/rrf_flag_mt.sv | 112 +++++++++++
 tb/tb_rrf_flag_mt.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_flag_mt.sv
// Per-thread architectural flag retirement register with checkpoint save/restore
// and a registered-select tri-state read port. Optional macro: RRF_FLAG_BYPASS_EN.
module rrf_flag_mt #(
  parameter int DATA_WIDTH  = 6,
  parameter int THREAD_BITS = 1,
  parameter int WPORTS      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read_clkEn,
  input  logic [THREAD_BITS-1:0]        read_thread,
  input  logic                          read0_oe,
  output logic [DATA_WIDTH:0]           read0_data,
  input  logic [WPORTS*DATA_WIDTH-1:0]  write_data,
  input  logic [WPORTS-1:0]             write_wen,
  input  logic [THREAD_BITS-1:0]        write_thread,
  input  logic                          save_en,
  input  logic [THREAD_BITS-1:0]        save_thread,
  input  logic                          restore_en,
  input  logic [THREAD_BITS-1:0]        restore_thread
);

  localparam int THREADS = 2 ** THREAD_BITS;

  logic [DATA_WIDTH-1:0]  data_reg  [THREADS];
  logic [DATA_WIDTH-1:0]  ckpt_reg  [THREADS];
  logic [THREADS-1:0]     dirty_reg;
  logic [DATA_WIDTH-1:0]  data_next [THREADS];
  logic [DATA_WIDTH-1:0]  ckpt_next [THREADS];
  logic [DATA_WIDTH-1:0]  wr_data   [THREADS];
  logic [THREADS-1:0]     dirty_next;

  logic [THREAD_BITS-1:0] read_thread_reg;
  logic                   read0_oe_reg;

  logic                   wvalid;
  logic [DATA_WIDTH-1:0]  wdat;
  logic [DATA_WIDTH:0]    rd_word;

  // Highest-index enabled port wins; lower ports are dropped whole.
  always_comb begin
    wvalid = 1'b0;
    wdat   = '0;
    for (int k = 0; k < WPORTS; k++) begin
      if (write_wen[k]) begin
        wvalid = 1'b1;
        wdat   = write_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < THREADS; gi++) begin : g_thread
      logic hit_w;
      logic hit_save;
      logic hit_rest;

      assign hit_w    = wvalid     && (write_thread   == THREAD_BITS'(gi));
      assign hit_save = save_en    && (save_thread    == THREAD_BITS'(gi));
      assign hit_rest = restore_en && (restore_thread == THREAD_BITS'(gi));

      assign wr_data[gi]    = hit_w ? wdat : data_reg[gi];
      // Restore overrides both the write and a same-thread save.
      assign data_next[gi]  = hit_rest ? ckpt_reg[gi] : wr_data[gi];
      assign ckpt_next[gi]  = (hit_save && !hit_rest) ? wr_data[gi] : ckpt_reg[gi];
      assign dirty_next[gi] = (hit_rest || hit_save) ? 1'b0 :
                              (hit_w ? 1'b1 : dirty_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < THREADS; t++) begin
        data_reg[t] <= '0;
        ckpt_reg[t] <= '0;
      end
      dirty_reg       <= '0;
      read_thread_reg <= '0;
      read0_oe_reg    <= 1'b1;
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        data_reg[t] <= data_next[t];
        ckpt_reg[t] <= ckpt_next[t];
      end
      dirty_reg <= dirty_next;
      if (read_clkEn) begin
        read_thread_reg <= read_thread;
        read0_oe_reg    <= read0_oe;
      end
    end
  end

`ifdef RRF_FLAG_BYPASS_EN
  // Forward this cycle's restore or retire write to the selected thread.
  always_comb begin
    if (restore_en && (restore_thread == read_thread_reg))
      rd_word = {1'b0, ckpt_reg[read_thread_reg]};
    else if (wvalid && (write_thread == read_thread_reg))
      rd_word = {1'b1, wdat};
    else
      rd_word = {dirty_reg[read_thread_reg], data_reg[read_thread_reg]};
  end
`else
  always_comb begin
    rd_word = {dirty_reg[read_thread_reg], data_reg[read_thread_reg]};
  end
`endif

  assign read0_data = read0_oe_reg ? rd_word : 'z;

endmodule

// File: tb/tb_rrf_flag_mt.sv
// Scoreboard bench for rrf_flag_mt: a reference model predicts each read after
// every driven cycle; predictions are queued and compared once the edge has passed.
module tb_rrf_flag_mt;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_clkEn;
  logic [0:0]  read_thread;
  logic        read0_oe;
  wire  [6:0]  read0_data;
  logic [17:0] write_data;
  logic [2:0]  write_wen;
  logic [0:0]  write_thread;
  logic        save_en;
  logic [0:0]  save_thread;
  logic        restore_en;
  logic [0:0]  restore_thread;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [6:0] exp_q[$];

  // Reference model state
  logic [5:0] m_data [2];
  logic [5:0] m_ckpt [2];
  logic [1:0] m_dirty;
  logic [0:0] m_rt;
  logic       m_oe;

  always #5 clk = ~clk;

  rrf_flag_mt #(.DATA_WIDTH(6), .THREAD_BITS(1), .WPORTS(3)) dut (
    .clk(clk), .rst(rst),
    .read_clkEn(read_clkEn), .read_thread(read_thread), .read0_oe(read0_oe),
    .read0_data(read0_data),
    .write_data(write_data), .write_wen(write_wen), .write_thread(write_thread),
    .save_en(save_en), .save_thread(save_thread),
    .restore_en(restore_en), .restore_thread(restore_thread)
  );

  task automatic check(string name, logic [6:0] got, logic [6:0] want);
    total_cnt++;
    if (got !== want) $display("FAIL %s: got %b expected %b", name, got, want);
    else pass_cnt++;
  endtask

  task automatic clear_ops();
    write_wen   = '0;
    write_data  = '0;
    save_en     = 1'b0;
    restore_en  = 1'b0;
  endtask

  task automatic model_reset();
    m_data[0] = '0; m_data[1] = '0;
    m_ckpt[0] = '0; m_ckpt[1] = '0;
    m_dirty = '0; m_rt = '0; m_oe = 1'b1;
  endtask

  // Predict the post-edge read, queue it, clock once, then pop and compare.
  task automatic drive_and_check(string name);
    logic [5:0] nd [2];
    logic [5:0] nc [2];
    logic [1:0] ndirty;
    logic [5:0] wd;
    logic       wv;
    logic [6:0] want;
    logic [6:0] got;
    wv = 1'b0; wd = '0;
    nd[0] = m_data[0]; nd[1] = m_data[1];
    nc[0] = m_ckpt[0]; nc[1] = m_ckpt[1];
    ndirty = m_dirty;
    if (write_wen[0]) begin wv = 1'b1; wd = write_data[5:0];   end
    if (write_wen[1]) begin wv = 1'b1; wd = write_data[11:6];  end
    if (write_wen[2]) begin wv = 1'b1; wd = write_data[17:12]; end
    if (wv) begin nd[write_thread] = wd; ndirty[write_thread] = 1'b1; end
    if (save_en) begin
      if (!(restore_en && restore_thread == save_thread)) nc[save_thread] = nd[save_thread];
      ndirty[save_thread] = 1'b0;
    end
    if (restore_en) begin
      nd[restore_thread] = m_ckpt[restore_thread];
      ndirty[restore_thread] = 1'b0;
    end
    if (read_clkEn) begin m_rt = read_thread; m_oe = read0_oe; end
    m_data[0] = nd[0]; m_data[1] = nd[1];
    m_ckpt[0] = nc[0]; m_ckpt[1] = nc[1];
    m_dirty = ndirty;
    want = m_oe ? {m_dirty[m_rt], m_data[m_rt]} : 7'bzzzzzzz;
    exp_q.push_back(want);
    @(posedge clk); #1;
    clear_ops();
    #1;
    got = exp_q.pop_front();
    $display("txn %-14s rt=%0d oe=%0d read0_data=%b expected=%b", name, m_rt, m_oe, read0_data, got);
    check(name, read0_data, got);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_ops();
    read_clkEn = 1'b0; read_thread = '0; read0_oe = 1'b0;
    write_thread = '0; save_thread = '0; restore_thread = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
    #1;
    check("reset_out", read0_data, 7'h00);
    read_clkEn = 1'b1; read0_oe = 1'b1; read_thread = 1'd0;
    drive_and_check("t1_rd_thr0");
    check("t1_const0", read0_data, 7'h00);
    read_thread = 1'd1;
    drive_and_check("t1_rd_thr1");
    check("t1_const1", read0_data, 7'h00);
  endtask

  task automatic test_merge();
    read_thread = 1'd1;
    write_wen = 3'b111; write_data = {6'h15, 6'h2A, 6'h01}; write_thread = 1'd1;
    drive_and_check("t2_merge_111");
    check("t2_const", read0_data, 7'h55);
    write_wen = 3'b011; write_data = {6'h15, 6'h2A, 6'h01}; write_thread = 1'd1;
    drive_and_check("merge_011");
    write_wen = 3'b001; write_data = {6'h3C, 6'h2A, 6'h07}; write_thread = 1'd1;
    drive_and_check("merge_001");
    write_wen = 3'b101; write_data = {6'h11, 6'h22, 6'h33}; write_thread = 1'd0;
    drive_and_check("merge_other_thr");
    write_wen = 3'b000; write_data = {6'h3F, 6'h3F, 6'h3F}; write_thread = 1'd1;
    drive_and_check("merge_none");
  endtask

  task automatic test_save_restore();
    read_thread = 1'd0;
    write_wen = 3'b001; write_data = {12'h0, 6'h0C}; write_thread = 1'd0;
    save_en = 1'b1; save_thread = 1'd0;
    drive_and_check("t3_write_save");
    check("t3_const_a", read0_data, 7'h0C);
    write_wen = 3'b010; write_data = {6'h0, 6'h33, 6'h0}; write_thread = 1'd0;
    drive_and_check("t3_write");
    check("t3_const_b", read0_data, 7'h73);
    restore_en = 1'b1; restore_thread = 1'd0;
    drive_and_check("t3_restore");
    check("t3_const_c", read0_data, 7'h0C);
  endtask

  task automatic test_restore_beats_write();
    read_thread = 1'd1;
    write_wen = 3'b100; write_data = {6'h1D, 12'h0}; write_thread = 1'd1;
    drive_and_check("thr1_write");
    save_en = 1'b1; save_thread = 1'd1;
    drive_and_check("thr1_save");
    write_wen = 3'b001; write_data = {12'h0, 6'h21}; write_thread = 1'd1;
    drive_and_check("thr1_dirty");
    restore_en = 1'b1; restore_thread = 1'd1;
    write_wen = 3'b001; write_data = {12'h0, 6'h3F}; write_thread = 1'd1;
    drive_and_check("t4_rest_wr");
    check("t4_const", read0_data, 7'h1D);
    // same-thread save+restore: restore wins and checkpoint stays
    write_wen = 3'b001; write_data = {12'h0, 6'h05}; write_thread = 1'd1;
    drive_and_check("thr1_dirty2");
    save_en = 1'b1; save_thread = 1'd1; restore_en = 1'b1; restore_thread = 1'd1;
    write_wen = 3'b010; write_data = {6'h0, 6'h2E, 6'h0}; write_thread = 1'd1;
    drive_and_check("save_rest_same");
    restore_en = 1'b1; restore_thread = 1'd1;
    drive_and_check("ckpt_unchanged");
    // different threads: both act
    write_wen = 3'b001; write_data = {12'h0, 6'h19}; write_thread = 1'd1;
    save_en = 1'b1; save_thread = 1'd1; restore_en = 1'b1; restore_thread = 1'd0;
    drive_and_check("save1_rest0");
    read_thread = 1'd0;
    drive_and_check("rd_thr0");
  endtask

  task automatic test_oe();
    read_clkEn = 1'b1; read0_oe = 1'b0; read_thread = 1'd1;
    drive_and_check("t5_oe_off");
    check("t5_z", read0_data, 7'bzzzzzzz);
    read_clkEn = 1'b0; read0_oe = 1'b1; read_thread = 1'd0;
    drive_and_check("t5_hold_z");
    read0_oe = 1'b0;
    drive_and_check("t5_hold_z2");
    read_clkEn = 1'b1; read0_oe = 1'b1; read_thread = 1'd0;
    drive_and_check("oe_on");
  endtask

  task automatic test_bypass();
    logic [6:0] same_want;
    read_clkEn = 1'b1; read0_oe = 1'b1; read_thread = 1'd0;
    write_wen = 3'b010; write_data = {6'h0, 6'h2B, 6'h0}; write_thread = 1'd0;
    #1;
`ifdef RRF_FLAG_BYPASS_EN
    same_want = 7'h6B;
`else
    same_want = {m_dirty[m_rt], m_data[m_rt]};
`endif
    check("t6_same_cycle", read0_data, same_want);
    drive_and_check("t6_next_cycle");
    check("t6_const", read0_data, 7'h6B);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    write_wen = 3'b111; write_data = {6'h3F, 6'h3F, 6'h3F}; write_thread = 1'd1;
    save_en = 1'b1; save_thread = 1'd1;
    read_clkEn = 1'b1; read0_oe = 1'b0; read_thread = 1'd1;
    @(posedge clk); #1;
    rst = 1'b0; clear_ops(); model_reset();
    read_clkEn = 1'b0; read0_oe = 1'b0; read_thread = 1'd1;
    #1;
    check("rst_mid_out", read0_data, 7'h00);
    drive_and_check("rst_mid_hold");
    read_clkEn = 1'b1; read0_oe = 1'b1; read_thread = 1'd1;
    drive_and_check("rst_mid_thr1");
    restore_en = 1'b1; restore_thread = 1'd1;
    drive_and_check("rst_mid_ckpt");
  endtask

  initial begin
    test_reset();
    test_merge();
    test_save_restore();
    test_restore_beats_write();
    test_oe();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
